// File: rtl/lc3_fetch_decode.sv
// LC-3 style fetch/decode front end: fetches one instruction at a time from a
// single-outstanding memory port, decodes it and offers it to execute with a valid/ready handshake.
module lc3_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  dec_opcode,
  output logic [2:0]  dec_dr,
  output logic [2:0]  dec_sr1,
  output logic [2:0]  dec_sr2,
  output logic        dec_imm_mode,
  output logic [15:0] dec_imm,
  output logic [15:0] dec_pc,
  output logic        dec_illegal,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] issue_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DECODE = 2'd2,
    S_ISSUE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [3:0]  r_opcode;
  logic [2:0]  r_dr;
  logic [2:0]  r_sr1;
  logic [2:0]  r_sr2;
  logic        r_imm_mode;
  logic [15:0] r_imm;
  logic [15:0] r_dec_pc;
  logic        r_illegal;
  logic [15:0] r_issue_count;
  logic        w_capture;
  logic        w_accept;

  // Handshake: an instruction transfers on a cycle where dec_valid && dec_ready;
  // dec_valid stays high and all dec_* fields hold until that cycle, and a
  // redirect in the same cycle cancels the transfer.
  assign w_capture = (r_state == S_WAIT) && mem_ack && !redirect;
  assign w_accept  = (r_state == S_ISSUE) && dec_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  w_next_state = S_WAIT;
        S_WAIT:   if (mem_ack) w_next_state = S_DECODE;
        S_DECODE: w_next_state = S_ISSUE;
        S_ISSUE:  if (dec_ready) w_next_state = S_FETCH;
        default:  w_next_state = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_ir          <= 16'h0000;
      r_opcode      <= 4'h0;
      r_dr          <= 3'd0;
      r_sr1         <= 3'd0;
      r_sr2         <= 3'd0;
      r_imm_mode    <= 1'b0;
      r_imm         <= 16'h0000;
      r_dec_pc      <= 16'h0000;
      r_illegal     <= 1'b0;
      r_issue_count <= 16'h0000;
    end else begin
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (w_capture) begin
        r_ir <= mem_rdata;
        r_pc <= r_pc + 16'h0001;
      end
      // PC has already advanced by the time DECODE runs, so it is the link value.
      if (!redirect && r_state == S_DECODE) begin
        r_opcode   <= r_ir[15:12];
        r_dr       <= r_ir[11:9];
        r_sr1      <= r_ir[8:6];
        r_sr2      <= r_ir[2:0];
        r_imm_mode <= r_ir[5];
        r_imm      <= {{11{r_ir[4]}}, r_ir[4:0]};
        r_dec_pc   <= r_pc;
        r_illegal  <= (r_ir[15:12] == 4'b1101);
      end
      if (w_accept) begin
        r_issue_count <= r_issue_count + 16'h0001;
      end
    end
  end

  assign mem_req      = (r_state == S_FETCH) || (r_state == S_WAIT);
  assign mem_addr     = r_pc;
  assign dec_valid    = (r_state == S_ISSUE);
  assign dec_opcode   = r_opcode;
  assign dec_dr       = r_dr;
  assign dec_sr1      = r_sr1;
  assign dec_sr2      = r_sr2;
  assign dec_imm_mode = r_imm_mode;
  assign dec_imm      = r_imm;
  assign dec_pc       = r_dec_pc;
  assign dec_illegal  = r_illegal;
  assign issue_count  = r_issue_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_lc3_fetch_decode.sv
// Bench for lc3_fetch_decode: table of decoded instructions plus directed
// sequences for redirect, hold, wrap and reset corner cases.
module tb_lc3_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_dr;
  logic [2:0]  dec_sr1;
  logic [2:0]  dec_sr2;
  logic        dec_imm_mode;
  logic [15:0] dec_imm;
  logic [15:0] dec_pc;
  logic        dec_illegal;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] issue_count;
  logic [1:0]  dbg_state;

  lc3_fetch_decode #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_opcode(dec_opcode), .dec_dr(dec_dr),
    .dec_sr1(dec_sr1), .dec_sr2(dec_sr2), .dec_imm_mode(dec_imm_mode),
    .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_illegal(dec_illegal),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .issue_count(issue_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_mode;
    logic [15:0] imm;
    logic        ill;
    int          hold;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_count;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_req();
    int k = 0;
    while (mem_req !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    chk("req_timeout", {15'd0, mem_req}, 16'd1);
  endtask

  task automatic chk_fields(input vec_t v, input string tag);
    chk({tag, "_op"},   {12'd0, dec_opcode}, {12'd0, v.op});
    chk({tag, "_dr"},   {13'd0, dec_dr}, {13'd0, v.dr});
    chk({tag, "_sr1"},  {13'd0, dec_sr1}, {13'd0, v.sr1});
    chk({tag, "_sr2"},  {13'd0, dec_sr2}, {13'd0, v.sr2});
    chk({tag, "_immm"}, {15'd0, dec_imm_mode}, {15'd0, v.imm_mode});
    chk({tag, "_imm"},  dec_imm, v.imm);
    chk({tag, "_ill"},  {15'd0, dec_illegal}, {15'd0, v.ill});
    chk({tag, "_pc"},   dec_pc, exp_pc);
  endtask

  // Fetch with a zero-wait ack one cycle after mem_req, ending in ISSUE.
  task automatic fetch_to_issue(input vec_t v);
    wait_req();
    chk("fetch_addr", mem_addr, exp_pc);
    step();
    mem_ack   = 1'b1;
    mem_rdata = v.instr;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom_range(0, 16'hFFFF);
    chk("decode_not_valid", {15'd0, dec_valid}, 16'd0);
    chk("decode_no_req", {15'd0, mem_req}, 16'd0);
    step();
    exp_pc = exp_pc + 16'h0001;
    chk("issue_valid", {15'd0, dec_valid}, 16'd1);
    chk_fields(v, "issue");
  endtask

  task automatic accept(input vec_t v);
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("hold_valid", {15'd0, dec_valid}, 16'd1);
      chk("hold_no_req", {15'd0, mem_req}, 16'd0);
      chk("hold_count", issue_count, exp_count);
      chk_fields(v, "hold");
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    exp_count = exp_count + 16'h0001;
    chk("accept_count", issue_count, exp_count);
    chk("accept_not_valid", {15'd0, dec_valid}, 16'd0);
    chk("next_addr", mem_addr, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1261, 4'h1, 3'd1, 3'd1, 3'd1, 1'b1, 16'h0001, 1'b0, 0};
    vecs[1] = '{16'h127F, 4'h1, 3'd1, 3'd1, 3'd7, 1'b1, 16'hFFFF, 1'b0, 5};
    vecs[2] = '{16'hD000, 4'hD, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1};
    vecs[3] = '{16'h5A83, 4'h5, 3'd5, 3'd2, 3'd3, 1'b0, 16'h0003, 1'b0, 2};
    vecs[4] = '{16'h0E30, 4'h0, 3'd7, 3'd0, 3'd0, 1'b1, 16'hFFF0, 1'b0, 0};
    vecs[5] = '{16'hF025, 4'hF, 3'd0, 3'd0, 3'd5, 1'b1, 16'h0005, 1'b0, 3};

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; dec_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0;
    step();
    step();
    rst = 1'b0;
    exp_pc = 16'h3000;
    exp_count = 16'h0000;
    chk("rst_req", {15'd0, mem_req}, 16'd1);
    chk("rst_addr", mem_addr, 16'h3000);
    chk("rst_valid", {15'd0, dec_valid}, 16'd0);
    chk("rst_count", issue_count, 16'h0000);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);
    chk("rst_imm", dec_imm, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      fetch_to_issue(vecs[i]);
      accept(vecs[i]);
    end

    // Redirect to the top of memory: link PC and next fetch wrap to 0000.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    exp_pc = 16'hFFFF;
    fetch_to_issue(vecs[0]);
    chk("wrap_dec_pc", dec_pc, 16'h0000);
    accept(vecs[0]);
    chk("wrap_next_addr", mem_addr, 16'h0000);

    // Redirect coincides with mem_ack: word dropped, refetch at new PC.
    wait_req();
    step();
    mem_ack = 1'b1; mem_rdata = 16'h1261;
    redirect = 1'b1; redirect_pc = 16'h4000;
    step();
    mem_ack = 1'b0; redirect = 1'b0;
    chk("drop_addr", mem_addr, 16'h4000);
    chk("drop_req", {15'd0, mem_req}, 16'd1);
    chk("drop_valid0", {15'd0, dec_valid}, 16'd0);
    step();
    step();
    chk("drop_valid2", {15'd0, dec_valid}, 16'd0);
    chk("drop_still_req", {15'd0, mem_req}, 16'd1);
    chk("drop_count", issue_count, exp_count);
    exp_pc = 16'h4000;
    fetch_to_issue(vecs[3]);

    // Redirect with dec_ready in ISSUE: not counted.
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h5000;
    step();
    dec_ready = 1'b0; redirect = 1'b0;
    chk("redir_valid", {15'd0, dec_valid}, 16'd0);
    chk("redir_count", issue_count, exp_count);
    chk("redir_addr", mem_addr, 16'h5000);
    exp_pc = 16'h5000;

    // Illegal opcode is issued, then reset lands in ISSUE.
    fetch_to_issue(vecs[2]);
    accept(vecs[2]);
    fetch_to_issue(vecs[2]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc = 16'h3000;
    exp_count = 16'h0000;
    chk("rst2_valid", {15'd0, dec_valid}, 16'd0);
    chk("rst2_addr", mem_addr, 16'h3000);
    chk("rst2_count", issue_count, 16'h0000);
    chk("rst2_op", {12'd0, dec_opcode}, 16'h0000);
    chk("rst2_ill", {15'd0, dec_illegal}, 16'd0);
    // Late ack arrives in FETCH and must be ignored.
    mem_ack = 1'b1; mem_rdata = 16'h1261;
    step();
    mem_ack = 1'b0;
    step();
    step();
    chk("late_ack_valid", {15'd0, dec_valid}, 16'd0);
    chk("late_ack_req", {15'd0, mem_req}, 16'd1);
    fetch_to_issue(vecs[0]);
    accept(vecs[0]);
    chk("post_rst_count", issue_count, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
